nios_security_motor_pwm: RTL
============================

# nios_security_motor_pwm

Avalon-MM slave that generates NUM_CH phase-aligned PWM motor drive signals from a shared period counter, with glitch-free (period-boundary) duty/period updates and a heartbeat watchdog that forces all motors off if software stops refreshing duties. It is the parametrised successor to the single-bit motor output PIO in the nios_security system and sits on the Nios II data master, driving ESC inputs directly.

## Interface
- NUM_CH, 4: number of PWM channels (1..12).
- CNT_W, 16: width of period counter, PERIOD and DUTY registers (≤32).
- WDOG_W, 24: width of watchdog counter and WDOG_LOAD (≤32).
- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous, active-low.
- address  in  4  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; upper unused bits ignored.
- readdata  out  32  read data, zero-extended; combinational, read latency 0.
- pwm_out  out  NUM_CH  PWM outputs, registered.
- irq  out  1  level interrupt = STATUS.TRIP & CTRL.IRQ_EN.

## Operation
- Register map (word): 0 CTRL {bit0 EN, bit1 WDOG_EN, bit2 IRQ_EN}; 1 PERIOD; 2 STATUS {bit0 TRIP (W1C), bit1 PEND (RO)}; 3 WDOG_LOAD; 4..4+NUM_CH-1 DUTY[i]; other addresses read 0, writes ignored.
- Write = chipselect & ~write_n. Reads return staging (software-written) values for PERIOD/DUTY, not active values.
- Reset values: CTRL 0, PERIOD 2^CNT_W-1, DUTY all 0, WDOG_LOAD all ones, TRIP 0, PEND 0, counter 0, watchdog count 0, pwm_out 0, irq 0.
- Two-level registers: writes to PERIOD/DUTY update staging and set PEND. Staging copies to active when EN=0 (every cycle) or at the boundary cycle (cnt == active PERIOD); PEND clears then, unless a PERIOD/DUTY write occurs in the same cycle (that write lands in staging, PEND stays 1, applies at next boundary).
- Counter: EN=0 → held at 0. EN=1 → counts 0..active PERIOD, wraps to 0; period = PERIOD+1 clocks.
- pwm_out[i] registered from (EN & cnt < active DUTY[i]). DUTY=0 → constant low; DUTY > PERIOD → constant high.
- Watchdog: count reloads from WDOG_LOAD on any DUTY write and on an EN 0→1 write; otherwise decrements when EN & WDOG_EN & count≠0. Reload beats decrement. Transition 1→0 sets TRIP and clears EN in the same edge.
- TRIP=1 blocks setting EN (EN bit of CTRL writes forced 0; other bits written normally). Writing STATUS bit0=1 clears TRIP; a trip in the same cycle wins.
- Write of EN=0 takes effect next edge; counter returns to 0, outputs low.

## Timing
- Register write visible on readdata the cycle after the write edge.
- EN 0→1 write at edge N: counter 0 at N+1, pwm_out reflects cnt=0 at N+2 (one output register stage).
- Duty update: new value affects comparison from cnt=0 following the boundary; pwm_out changes one cycle later. No partial or runt pulses.
- Watchdog trip: pwm_out low no later than two edges after count reaches 0; irq asserts the edge after TRIP.
- Asynchronous reset mid-period: all outputs low immediately, no glitch on deassertion.

## Structure
- Package nios_security_motor_pkg: register offsets, CTRL/STATUS bit indices, reset constants.
- Sub-module nios_security_pwm_ch: per-channel active duty register plus comparator and output flop, instantiated NUM_CH times; top holds bus decode, counter, staging registers, watchdog.

## Test plan
- Reset, read all registers → PERIOD=0xFFFF, WDOG_LOAD=0xFFFFFF, others 0; pwm_out=0.
- PERIOD=9, DUTY0=3, DUTY1=0, DUTY2=10, EN=1 → ch0 high 3/low 7 clocks repeating, ch1 always low, ch2 always high.
- While running PERIOD=9/DUTY0=3, write DUTY0=7 mid-period → current period keeps 3-high, next period 7-high; write on boundary cycle → applied one period later, PEND=1 meanwhile.
- WDOG_LOAD=20, WDOG_EN=1, EN=1, no duty writes → TRIP=1, EN=0, pwm_out=0 within 22 clocks; IRQ_EN=1 → irq=1; write EN=1 → ignored; W1C STATUS → TRIP=0, irq=0, then EN=1 accepted.
- Duty write every 15 clocks with WDOG_LOAD=20 → never trips over 1000 clocks.
- Assert reset_n low mid-pulse → pwm_out 0 asynchronously; after release registers at reset values.

Source files
------------

// File: rtl/nios_security_motor_pkg.sv
// Shared definitions for the nios_security motor PWM block: register word
// offsets, CTRL/STATUS bit positions and reset constants.
package nios_security_motor_pkg;

  // Word offsets on the Avalon-MM slave.
  localparam logic [3:0] ADDR_CTRL      = 4'd0;
  localparam logic [3:0] ADDR_PERIOD    = 4'd1;
  localparam logic [3:0] ADDR_STATUS    = 4'd2;
  localparam logic [3:0] ADDR_WDOG_LOAD = 4'd3;
  localparam logic [3:0] ADDR_DUTY0     = 4'd4;

  // CTRL bit positions.
  localparam int CTRL_EN      = 0;
  localparam int CTRL_WDOG_EN = 1;
  localparam int CTRL_IRQ_EN  = 2;

  // STATUS bit positions.
  localparam int STAT_TRIP = 0;
  localparam int STAT_PEND = 1;

  // Largest channel count that fits in the 4-bit word address space.
  localparam int MAX_CH = 12;

  // Reset values of single-bit control state.
  localparam logic RST_EN      = 1'b0;
  localparam logic RST_WDOG_EN = 1'b0;
  localparam logic RST_IRQ_EN  = 1'b0;
  localparam logic RST_TRIP    = 1'b0;
  localparam logic RST_PEND    = 1'b0;

  // Word address of DUTY[ch].
  function automatic logic [3:0] duty_addr(input int ch);
    return ADDR_DUTY0 + 4'(ch);
  endfunction

endpackage

// File: rtl/nios_security_pwm_ch.sv
// One PWM channel: holds the active duty value, compares it with the shared
// period counter and registers the result onto the output pin.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   i_apply        copy staged duty into the active register this cycle
//   i_duty_stg     software-written (staged) duty value
//   i_en           global PWM enable
//   i_cnt          shared period counter
//   o_pwm          registered PWM output
module nios_security_pwm_ch #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_apply,
  input  logic [CNT_W-1:0] i_duty_stg,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_cnt,
  output logic             o_pwm
);

  logic [CNT_W-1:0] r_duty_act;
  logic             r_pwm;

  // The comparison uses the active duty of the current period; a newly
  // applied duty takes effect from the cnt=0 cycle after the boundary, so a
  // period never mixes old and new values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_duty_act <= '0;
      r_pwm      <= 1'b0;
    end else begin
      if (i_apply) begin
        r_duty_act <= i_duty_stg;
      end
      r_pwm <= i_en & (i_cnt < r_duty_act);
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/nios_security_motor_pwm.sv
// Avalon-MM motor PWM controller for the nios_security system. Generates
// NUM_CH phase-aligned PWM outputs from one shared period counter. PERIOD and
// DUTY are double-buffered and applied only at the period boundary (or
// continuously while disabled). A heartbeat watchdog, reloaded by DUTY writes,
// trips and disables all outputs when software stops refreshing duties.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   address             word address (0 CTRL, 1 PERIOD, 2 STATUS,
//                       3 WDOG_LOAD, 4.. DUTY[i])
//   chipselect, write_n slave select and active-low write strobe
//   writedata           write data, unused upper bits ignored
//   readdata            combinational zero-extended read data
//   pwm_out             registered PWM outputs
//   irq                 level interrupt from TRIP gated by IRQ_EN
module nios_security_motor_pwm
  import nios_security_motor_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int WDOG_W = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              irq
);

  // Control state.
  logic r_en;
  logic r_wdog_en;
  logic r_irq_en;
  logic r_trip;
  logic r_pend;
  logic r_irq;

  // Period counter and double-buffered period.
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period_stg;
  logic [CNT_W-1:0] r_period_act;

  // Staged duties; active copies live in the channel instances.
  logic [CNT_W-1:0] r_duty_stg [NUM_CH];

  // Watchdog.
  logic [WDOG_W-1:0] r_wdog_load;
  logic [WDOG_W-1:0] r_wdog_cnt;

  // Bus decode.
  logic              w_wr;
  logic              w_wr_ctrl;
  logic              w_wr_period;
  logic              w_wr_status;
  logic              w_wr_wdog;
  logic [NUM_CH-1:0] w_wr_duty;
  logic              w_duty_wr_any;
  logic              w_stg_wr;

  // Sequencing.
  logic w_boundary;
  logic w_apply;
  logic w_en_req;
  logic w_en_rise;
  logic w_wd_reload;
  logic w_wd_dec;
  logic w_trip_evt;

  // Upper writedata bits beyond the register widths carry no meaning.
  logic w_unused_wdata;
  assign w_unused_wdata = ^writedata;

  assign w_wr        = chipselect & ~write_n;
  assign w_wr_ctrl   = w_wr & (address == ADDR_CTRL);
  assign w_wr_period = w_wr & (address == ADDR_PERIOD);
  assign w_wr_status = w_wr & (address == ADDR_STATUS);
  assign w_wr_wdog   = w_wr & (address == ADDR_WDOG_LOAD);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_duty_dec
    assign w_wr_duty[g] = w_wr & (address == duty_addr(g));
  end

  assign w_duty_wr_any = |w_wr_duty;
  assign w_stg_wr      = w_wr_period | w_duty_wr_any;

  // While disabled the staged values flow straight through every cycle;
  // while running they only move at the last count of the period.
  assign w_boundary = (r_cnt == r_period_act);
  assign w_apply    = ~r_en | w_boundary;

  // A trip latched in STATUS blocks software from re-enabling the outputs.
  assign w_en_req  = writedata[CTRL_EN] & ~r_trip;
  assign w_en_rise = w_wr_ctrl & w_en_req & ~r_en;

  // Reload has priority over decrement, so a trip only fires on a genuine
  // 1->0 countdown with no heartbeat in the same cycle.
  assign w_wd_reload = w_duty_wr_any | w_en_rise;
  assign w_wd_dec    = r_en & r_wdog_en & (r_wdog_cnt != '0);
  assign w_trip_evt  = ~w_wd_reload & w_wd_dec & (r_wdog_cnt == WDOG_W'(1));

  // CTRL, STATUS and interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en      <= RST_EN;
      r_wdog_en <= RST_WDOG_EN;
      r_irq_en  <= RST_IRQ_EN;
      r_trip    <= RST_TRIP;
      r_pend    <= RST_PEND;
      r_irq     <= 1'b0;
    end else begin
      if (w_trip_evt) begin
        r_en <= 1'b0;
      end else if (w_wr_ctrl) begin
        r_en <= w_en_req;
      end
      if (w_wr_ctrl) begin
        r_wdog_en <= writedata[CTRL_WDOG_EN];
        r_irq_en  <= writedata[CTRL_IRQ_EN];
      end

      // A trip in the same cycle as a W1C write wins.
      if (w_trip_evt) begin
        r_trip <= 1'b1;
      end else if (w_wr_status & writedata[STAT_TRIP]) begin
        r_trip <= 1'b0;
      end

      // A staging write on the apply cycle keeps PEND set: that value is
      // still waiting for the next boundary.
      if (w_stg_wr) begin
        r_pend <= 1'b1;
      end else if (w_apply) begin
        r_pend <= 1'b0;
      end

      r_irq <= r_trip & r_irq_en;
    end
  end

  // Period counter and period double buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt        <= '0;
      r_period_stg <= '1;
      r_period_act <= '1;
    end else begin
      if (!r_en || w_boundary) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_apply) begin
        r_period_act <= r_period_stg;
      end
      if (w_wr_period) begin
        r_period_stg <= writedata[CNT_W-1:0];
      end
    end
  end

  // Staged duties.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_duty_stg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_wr_duty[i]) begin
          r_duty_stg[i] <= writedata[CNT_W-1:0];
        end
      end
    end
  end

  // Watchdog.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wdog_load <= '1;
      r_wdog_cnt  <= '0;
    end else begin
      if (w_wr_wdog) begin
        r_wdog_load <= writedata[WDOG_W-1:0];
      end
      if (w_wd_reload) begin
        r_wdog_cnt <= r_wdog_load;
      end else if (w_wd_dec) begin
        r_wdog_cnt <= r_wdog_cnt - WDOG_W'(1);
      end
    end
  end

  // Channels.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    nios_security_pwm_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_apply    (w_apply),
      .i_duty_stg (r_duty_stg[g]),
      .i_en       (r_en),
      .i_cnt      (r_cnt),
      .o_pwm      (pwm_out[g])
    );
  end

  // Read mux; PERIOD/DUTY return the staged values.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL: begin
        readdata[CTRL_EN]      = r_en;
        readdata[CTRL_WDOG_EN] = r_wdog_en;
        readdata[CTRL_IRQ_EN]  = r_irq_en;
      end
      ADDR_PERIOD:    readdata = 32'(r_period_stg);
      ADDR_STATUS: begin
        readdata[STAT_TRIP] = r_trip;
        readdata[STAT_PEND] = r_pend;
      end
      ADDR_WDOG_LOAD: readdata = 32'(r_wdog_load);
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (address == duty_addr(i)) begin
            readdata = 32'(r_duty_stg[i]);
          end
        end
      end
    endcase
  end

  assign irq = r_irq;

endmodule
